// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 19-bit pipelined CPU.
//
// Holds the program counter, presents it to a combinational instruction
// memory, and owns the IF/ID pipeline register. The hazard unit stalls fetch
// through PCwrite / IF_IDwrite. A taken branch from EX redirects the PC and
// flushes IF/ID to a bubble.
//
// Parameters
//   PC_WIDTH   program counter / word address width
//   NOP_INSTR  instruction word placed in IF/ID on reset or flush
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   PCwrite        1 = PC may advance this cycle
//   IF_IDwrite     1 = IF/ID may load this cycle
//   branch_taken   redirect request from EX (overrides any stall)
//   branch_target  redirect address
//   imem_addr      instruction memory address (current PC)
//   imem_data      instruction at imem_addr, same cycle
//   ID_instr       IF/ID instruction
//   ID_pc          PC of ID_instr
//   ID_valid       0 = bubble
//   ID_rs, ID_rt   register fields [10:8] / [7:5] of ID_instr
//   stall_count    saturating count of stalled cycles
//
// Build option
//   IF_STALL_COUNT_EN  when defined, stall_count counts edges with PCwrite
//                      low (no reset, no branch) and saturates at 16'hFFFF.
//                      When undefined, no counter exists and stall_count
//                      is tied to zero.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int          PC_WIDTH  = 8,
  parameter logic [18:0] NOP_INSTR = 19'h00000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCwrite,
  input  logic                IF_IDwrite,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [18:0]         imem_data,
  output logic [18:0]         ID_instr,
  output logic [PC_WIDTH-1:0] ID_pc,
  output logic                ID_valid,
  output logic [2:0]          ID_rs,
  output logic [2:0]          ID_rt,
  output logic [15:0]         stall_count
);

  logic [PC_WIDTH-1:0] pc;

  // Priority: reset, then branch flush, then the independent PC / IF-ID
  // write enables. A branch wins over a load-use stall.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others (ID_pc takes the old PC).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      ID_instr <= NOP_INSTR;
      ID_pc    <= '0;
      ID_valid <= 1'b0;
    end else if (branch_taken) begin
      pc       <= branch_target;
      ID_instr <= NOP_INSTR;
      ID_pc    <= '0;
      ID_valid <= 1'b0;
    end else begin
      // Wraps from all-ones to zero silently.
      if (PCwrite) begin
        pc <= pc + PC_WIDTH'(1);
      end
      if (IF_IDwrite) begin
        ID_instr <= imem_data;
        ID_pc    <= pc;
        ID_valid <= 1'b1;
      end
    end
  end

  assign imem_addr = pc;

  // Register fields decoded straight from the IF/ID register, so they only
  // move on clock edges.
  assign ID_rs = ID_instr[10:8];
  assign ID_rt = ID_instr[7:5];

`ifdef IF_STALL_COUNT_EN
  logic [15:0] stall_cnt;

  // Counts stalled edges only; a branch edge is not a stall even when the
  // hazard unit still holds PCwrite low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!branch_taken && !PCwrite && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 19-bit pipelined CPU. It holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It consumes `PCwrite` and `IF_IDwrite` from the hazard detection unit to stall fetch, and the branch redirect from EX to flush. It produces the decoded `ID_rs` / `ID_rt` fields that the hazard detection unit compares against `EX_rt`.

## Interface
Parameters:
- `PC_WIDTH`, 8: program counter / instruction-memory address width (word addressed).
- `NOP_INSTR`, 19'h00000: instruction word inserted into IF/ID on reset or flush.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  input  1  rising-edge clock for all state.
  - `rst`  input  1  synchronous, active-high reset.
- Hazard unit interface:
  - `PCwrite`  input  1  1 = PC may update this cycle.
  - `IF_IDwrite`  input  1  1 = IF/ID register may load this cycle.
- Branch redirect from EX:
  - `branch_taken`  input  1  redirect request from EX.
  - `branch_target`  input  PC_WIDTH  redirect address.
- Instruction memory (combinational read):
  - `imem_addr`  output  PC_WIDTH  equals current PC.
  - `imem_data`  input  19  instruction at `imem_addr`, same cycle.
- IF/ID register outputs:
  - `ID_instr`  output  19  IF/ID instruction.
  - `ID_pc`  output  PC_WIDTH  PC of `ID_instr`.
  - `ID_valid`  output  1  0 = bubble.
  - `ID_rs`  output  3  `ID_instr[10:8]`, combinational from the IF/ID register.
  - `ID_rt`  output  3  `ID_instr[7:5]`, combinational from the IF/ID register.
- Performance counter:
  - `stall_count`  output  16  stall-cycle counter; see Configuration.

## Operation
- Instruction format: opcode [18:14], rd [13:11], rs [10:8], rt [7:5], imm/func [4:0]. Only rs and rt are extracted here.
- Each rising edge applies the first matching rule, in this priority:
  1. `rst`:
     - PC = 0.
     - `ID_instr` = NOP_INSTR, `ID_pc` = 0, `ID_valid` = 0.
     - `stall_count` = 0.
  2. `branch_taken` (flush):
     - PC = `branch_target`.
     - `ID_instr` = NOP_INSTR, `ID_pc` = 0, `ID_valid` = 0.
     - Applies regardless of `PCwrite` / `IF_IDwrite`. A branch overrides a load-use stall.
  3. Normal:
     - If `PCwrite` = 1: PC = PC + 1, modulo 2^PC_WIDTH. From all-ones, PC wraps to 0 with no flag.
     - If `PCwrite` = 0: PC holds.
     - If `IF_IDwrite` = 1: `ID_instr` = `imem_data`, `ID_pc` = PC (pre-increment value), `ID_valid` = 1.
     - If `IF_IDwrite` = 0: all IF/ID fields hold.
- `PCwrite` and `IF_IDwrite` are handled independently; no consistency check. The hazard unit always drives them equal.
- `imem_addr` is a continuous copy of the PC register.
- No internal FSM beyond the PC register and IF/ID register. The two states are RUN (writes enabled) and STALL (writes low); no state persists beyond the registers.

## Timing
- Fetch latency: the instruction at PC = N appears on `ID_instr` after the next rising edge, provided `IF_IDwrite` = 1 and there is no branch.
- Throughput: one instruction per cycle while unstalled.
- Stall: while `PCwrite` = `IF_IDwrite` = 0, the PC and the IF/ID register hold their values exactly. The same `imem_addr` is presented again on the next cycle.
- The hazard unit registers its outputs, so stall inputs arrive already aligned to the cycle they apply to. This block samples them on the same edge with no extra delay.
- Branch penalty: the cycle after `branch_taken`, `ID_valid` = 0 and `imem_addr` = target. The target instruction reaches ID one cycle later.
- Reset mid-stall or mid-branch: reset wins; all state returns to its reset values on that edge.
- `ID_rs` / `ID_rt` change only on clock edges, because they derive from registered `ID_instr`.

## Configuration
- Macro `IF_STALL_COUNT_EN`.
- Defined:
  - `stall_count` increments by 1 on each edge where `rst` = 0, `branch_taken` = 0 and `PCwrite` = 0.
  - It saturates at 16'hFFFF; no wrap.
  - It is cleared only by reset.
- Undefined:
  - No counter register is synthesized.
  - `stall_count` is tied to 16'h0000.
- All other behaviour is identical in both builds.

## Test plan
1. Reset: assert `rst` for 2 cycles with `imem_data` = 19'h7FFFF. Then `imem_addr` = 0, `ID_valid` = 0, `ID_instr` = 0, `ID_pc` = 0, `stall_count` = 0.
2. Sequential fetch: release reset, hold `PCwrite` = `IF_IDwrite` = 1, with `imem_data` = {opcode 1, rd 2, rs 3, rt 4, 0}. After 1 edge: `ID_pc` = 0, `ID_rs` = 3, `ID_rt` = 4, `ID_valid` = 1, `imem_addr` = 1.
3. Stall: at PC = 5, drive `PCwrite` = `IF_IDwrite` = 0 for 2 cycles. `imem_addr` stays 5 and `ID_pc` stays 4 for both cycles. With the macro, `stall_count` = 2. Fetch resumes at 5.
4. Branch during stall: with PC = 7 and stall asserted, pulse `branch_taken` with `branch_target` = 8'h40. Next cycle: `imem_addr` = 8'h40, `ID_valid` = 0, `stall_count` unchanged. The cycle after: `ID_pc` = 8'h40.
5. Wrap: branch to 8'hFF, then run unstalled. `ID_pc` = 8'hFF, then `ID_pc` = 0, with `imem_addr` = 0 then 1.
6. Counter saturation (macro defined): hold stall for 65,540 cycles. `stall_count` reaches 16'hFFFF and stays there. Macro undefined: `stall_count` remains 0.
